// File: rtl/dsi_pkt_framer.sv
// ---------------------------------------------------------------------------
// dsi_pkt_framer : frames DSI short/long packets (header+ECC, payload, CRC-16)
// onto 64-bit lane beats. Define DSI_PKT_CRC_EN to generate the payload CRC.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsi_pkt_framer #(
  parameter int unsigned MAX_WC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_long,
  input  logic [7:0]  cmd_di,
  input  logic [15:0] cmd_wc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [3:0]  out_bytes,
  output logic        cmd_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        short_q, short_d;
  logic [16:0] rem_q, rem_d;
  logic [31:0] hold_q, hold_d;
  logic        err_q, err_d;

  logic        w_acc, w_drop, w_need_in, w_last, w_xfer;
  logic [15:0] w_crc;
  logic [63:0] w_src, w_long_data;

  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] e;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return e;
  endfunction

`ifdef DSI_PKT_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [3:0]  w_in_cnt;

  // Reflected CCITT update, one bit at a time LSB first, over the first cnt bytes.
  function automatic logic [15:0] crc_upd(input logic [15:0] seed, input logic [63:0] data,
                                          input logic [3:0] cnt);
    logic [15:0] c;
    logic        fb;
    c = seed;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < cnt) begin
        for (int t = 0; t < 8; t++) begin
          fb = c[0] ^ data[8*b+t];
          c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
      end
    end
    return c;
  endfunction

  assign w_in_cnt = (rem_q >= 17'd14) ? 4'd8 : (rem_q[3:0] - 4'd6);
  assign w_crc    = w_need_in ? crc_upd(crc_q, in_data, w_in_cnt) : crc_q;
`else
  assign w_crc    = 16'h0000;
`endif

  // rem_q counts stream bytes (header+payload+CRC) still to send, from this beat on.
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_drop    = w_acc && cmd_long && (32'(cmd_wc) > MAX_WC);
  assign w_need_in = !short_q && (rem_q > 17'd6);
  assign w_last    = short_q || (rem_q <= 17'd8);
  assign w_xfer    = out_valid && out_ready;
  assign w_src     = {in_data[31:0], hold_q};

  always_comb begin
    w_long_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (rem_q > 17'(i + 2))
        w_long_data[8*i +: 8] = w_src[8*i +: 8];
      else if (rem_q == 17'(i + 2))
        w_long_data[8*i +: 8] = w_crc[7:0];
      else if (rem_q == 17'(i + 1))
        w_long_data[8*i +: 8] = w_crc[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      short_q <= 1'b0;
      rem_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
`ifdef DSI_PKT_CRC_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
`ifdef DSI_PKT_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    short_d = short_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    err_d   = w_drop;
`ifdef DSI_PKT_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_acc && !w_drop) begin
          state_d = S_BODY;
          short_d = !cmd_long;
          rem_d   = 17'(cmd_wc) + 17'd6;
          hold_d  = {2'b00, dsi_ecc({cmd_wc, cmd_di}), cmd_wc, cmd_di};
`ifdef DSI_PKT_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end
      end
      default: begin
        if (w_xfer) begin
          rem_d  = rem_q - 17'd8;
          // Upper half of this input beat becomes the lower half of the next output beat.
          hold_d = in_data[63:32];
`ifdef DSI_PKT_CRC_EN
          if (w_need_in) crc_d = w_crc;
`endif
          if (w_last) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE) && reset;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_bytes = '0;
    if (state_q == S_BODY) begin
      out_valid = w_need_in ? in_valid : 1'b1;
      in_ready  = w_need_in && in_valid && out_ready;
      out_last  = w_last;
      if (short_q) begin
        out_data  = {32'h0, hold_q};
        out_bytes = 4'd4;
      end else begin
        out_data  = w_long_data;
        out_bytes = w_last ? rem_q[3:0] : 4'd8;
      end
    end
  end

  assign cmd_err = err_q;

endmodule

`default_nettype wire

// File: doc/dsi_pkt_framer.md
DSI_PKT_FRAMER -- requirements
Module: dsi_pkt_framer

Interface
REQ-001 Parameter MAX_WC, default 4096, is the largest accepted long-packet word count in bytes.
REQ-002 Clocking is decided: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  packet command offered.
REQ-006 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-007 cmd_long  input  1  1 = long packet, 0 = short packet.
REQ-008 cmd_di  input  8  data identifier (VC + data type), header byte 0.
REQ-009 cmd_wc  input  16  long: payload byte count; short: two data bytes (header bytes 1, 2 = wc[7:0], wc[15:8]).
REQ-010 in_valid / in_ready  input / output  1 / 1  payload beat handshake.
REQ-011 in_data  input  64  payload beat, byte n in bits [8n+7:8n], DSI byte order.
REQ-012 out_valid / out_ready  output / input  1 / 1  lane-data beat handshake.
REQ-013 out_data  output  64  framed beat, same byte order as in_data.
REQ-014 out_last  output  1  final beat of packet.
REQ-015 out_bytes  output  4  valid bytes in beat (1..8); 8 unless out_last.
REQ-016 cmd_err  output  1  one-cycle pulse when long command with cmd_wc > MAX_WC is dropped.

Function
REQ-017 States IDLE, BODY; cmd_ready = 1 only in IDLE.
REQ-018 Accepted command: header = {di, wc[7:0], wc[15:8], ECC}, ECC = DSI 6-bit Hamming over 24 header bits, ECC[7:6] = 0; state -> BODY next cycle.
REQ-019 Rejected command (long, wc > MAX_WC): accepted, cmd_err pulses next cycle, state stays IDLE, no output.
REQ-020 Short packet: one beat, bytes 0-3 = header, bytes 4-7 = 0, out_bytes = 4, out_last = 1; no payload consumed.
REQ-021 Long packet stream = header(4) + payload(WC) + CRC(2, low byte first); beats = ceil((WC+6)/8); out_bytes on last = ((WC+5) mod 8)+1.
REQ-022 Output beat k carries stream bytes 8k..8k+7; needs input beat k iff 8k < WC; input beat k is consumed in the same cycle output beat k transfers.
REQ-023 out_valid for beat k requires in_valid when REQ-022 needs input; in_ready = out_valid && out_ready for such beats, else 0.
REQ-024 Input bytes beyond WC in last input beat are ignored; output bytes beyond out_bytes are 0.
REQ-025 CRC: CRC-16, poly x^16+x^12+x^5+1, seed 0xFFFF, bit-serial LSB-first per byte, over payload bytes only; WC = 0 gives 0xFFFF.
REQ-026 Output latency: beat 0 presented the cycle after command accept (given input available); one beat per cycle thereafter with no bubbles while in_valid and out_ready held high.
REQ-027 out_valid && !out_ready: out_data, out_last, out_bytes held stable.
REQ-028 Transfer of out_last beat returns to IDLE; next command may be accepted the following cycle.

Reset
REQ-029 Reset asserted: state IDLE, cmd_ready = 0 while asserted then 1, out_valid = 0, in_ready = 0, out_last = 0, out_bytes = 0, out_data = 0, cmd_err = 0, CRC = 0xFFFF.
REQ-030 Reset mid-packet aborts packet; no further beats of it emitted after release.

Configuration
REQ-031 Macro DSI_PKT_CRC_EN defined: CRC per REQ-025; undefined: CRC logic absent, CRC bytes transmitted as 0x0000, framing unchanged.

Verification
REQ-032 Short: di=0x37, wc=0x01F0 -> one beat, bytes 37 F0 01 3F 00 00 00 00, out_bytes=4, out_last=1.
REQ-033 Long WC=0, di=0x39 -> one beat, bytes 39 00 00 ECC FF FF 00 00, out_bytes=6; no in_ready pulse; with macro undefined CRC bytes 00 00.
REQ-034 Long WC=8, payload 01..08 -> beat0 39 08 00 ECC 01 02 03 04, beat1 05 06 07 08 CRClo CRChi 00 00, out_bytes=6; CRC matches software model.
REQ-035 Long WC=MAX_WC+1 -> cmd_err one pulse, no out_valid, next valid command framed normally.
REQ-036 Random out_ready/in_valid throttling on WC=100 -> output stable while stalled, 14 beats, out_bytes=2 on last, byte stream equals model.
REQ-037 Reset asserted on beat 3 of WC=64 packet -> all outputs reset values, following packet framed correctly.
